hwpe_instr_dec: RTL and testbench
=================================

HWPE_INSTR_DEC -- requirements
Module: hwpe_instr_dec

Interface
REQ-001 Parameter NUM_PE, default 16, number of PEs addressed; PE_W = clog2(NUM_PE).
REQ-002 Parameter NUM_ACC, default 8, accumulator registers per PE; ACC_W = clog2(NUM_ACC).
REQ-003 Parameter DLY_W, default 3, width of the fmap-start delay counter.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 instr  in  32  custom instruction: funct7=[31:25], rs2=[24:20], rs1=[19:15], rd=[11:7].
REQ-007 rs1_data  in  32  rs1 operand.
REQ-008 eai_req_valid, eai_req_ready  in  1 each  handshake; accept = valid & ready.
REQ-009 kernel_333, layer_type  in  1 each  mode bits from cfg registers.
REQ-010 matrix_done  in  1  one-cycle pulse, matrix MAC finished.
REQ-011 wr_fmap_addr, wr_cfg  out  1 each  register-write decodes.
REQ-012 acc_wen out 1; acc_w_pe_id out PE_W; acc_w_acc_id out ACC_W; acc_w_wd out 32  accumulator write.
REQ-013 acc_ren out 1; acc_r_pe_id out PE_W; acc_r_acc_id out ACC_W  accumulator read.
REQ-014 relu_ren out 1; relu_acc_id out ACC_W  ReLU read-out.
REQ-015 soft_rst  out  1  registered block reset request.
REQ-016 kernel_st, fmap_st, conv_st  out  1 each  single-cycle start pulses.
REQ-017 busy, done_imm, err  out  1 each  MAC active, instr completes immediately, sticky error.

Function
REQ-020 Decodes (wr_fmap_addr, wr_cfg, acc_wen, acc_ren, relu_ren) SHALL be combinational funct7 compares, not gated by handshake.
REQ-021 Field mapping: acc_w_pe_id=rs2[PE_W-1:0], acc_w_acc_id=rd[ACC_W-1:0], acc_w_wd=rs1_data, acc_r_acc_id=rs1[ACC_W-1:0], acc_r_pe_id=rs2[PE_W-1:0], relu_acc_id=rs2[ACC_W-1:0].
REQ-022 done_imm SHALL be 0 exactly for MatrixMac and ReLU funct7 codes, else 1.
REQ-023 soft_rst SHALL be 1 the cycle after an accepted Reset instruction, 1 cycle wide.
REQ-024 FSM states IDLE, ARM, DELAY, RUN; busy=1 in ARM, DELAY, RUN.
REQ-025 IDLE->ARM on accepted MatrixMac; ARM lasts exactly 1 cycle (cfg write settle).
REQ-026 Leaving ARM SHALL pulse kernel_st; delay D = 0 if kernel_333, 2 if layer_type, else 3, latched at ARM.
REQ-027 D=0: fmap_st pulses with kernel_st, ARM->RUN; D>0: ARM->DELAY, counter loads D-1, fmap_st pulses when counter=0, then RUN.
REQ-028 RUN->IDLE on matrix_done; matrix_done in ARM/DELAY SHALL be ignored.
REQ-029 Accepted MatrixMac while busy SHALL be dropped and set err.
REQ-030 conv_st SHALL pulse 1 cycle on accepted acc_ren with rs1[4]=1 or relu_ren with rs2[4]=1 while in RUN, or in IDLE if the last RUN completed since the last Reset (done flag).
REQ-031 Same chain request with done flag clear and state not RUN SHALL produce no conv_st and set err.
REQ-032 Repeated valid without ready SHALL NOT retrigger any pulse.

Reset
REQ-040 rst or soft_rst SHALL force IDLE, clear counter, done flag, err, all pulses; soft_rst itself clears only on rst.
REQ-041 rst mid-DELAY SHALL suppress the pending fmap_st.

Configuration
REQ-050 Macro HWPE_DEC_ERR_EN: defined -> err register per REQ-029/031; undefined -> err tied 0, no error logic, other behaviour unchanged.

Structure
REQ-060 funct7 codes, state encoding and delay constants SHALL live in shared package hwpe_dec_pkg.
REQ-061 Start sequencer (ARM/DELAY/count) SHALL be sub-module hwpe_start_seq.

Verification
REQ-070 Accepted MatrixMac, kernel_333=1 -> kernel_st and fmap_st both at cycle 2, busy until matrix_done.
REQ-071 layer_type=1, kernel_333=0 -> kernel_st cycle 2, fmap_st cycle 4; both 0 -> fmap_st cycle 5.
REQ-072 MatrixMac during RUN -> no pulses, err=1 (macro on), err=0 (macro off).
REQ-073 relu_ren rs2=0x13 after matrix_done -> conv_st 1 cycle, relu_acc_id=3; before any MAC -> no conv_st, err=1.
REQ-074 Reset instr accepted in DELAY -> soft_rst next cycle, FSM IDLE, no fmap_st.
REQ-075 NUM_PE=32: acc_wen, rs2=0x1F, rd=5, rs1_data=0xDEADBEEF -> pe_id=31, acc_id=5, wd=0xDEADBEEF.

Source files
------------

// File: rtl/hwpe_dec_pkg.sv
// Shared definitions for the HWPE custom-instruction decoder: funct7 opcodes,
// start-sequencer state encoding and fmap-start delay constants.
package hwpe_dec_pkg;

  // funct7 opcodes of the custom instruction set
  localparam logic [6:0] F7_WR_FMAP = 7'h01;  // write fmap address register
  localparam logic [6:0] F7_WR_CFG  = 7'h02;  // write config register
  localparam logic [6:0] F7_ACC_WR  = 7'h03;  // accumulator write
  localparam logic [6:0] F7_ACC_RD  = 7'h04;  // accumulator read
  localparam logic [6:0] F7_RELU    = 7'h05;  // ReLU read-out
  localparam logic [6:0] F7_MAC     = 7'h06;  // start matrix MAC
  localparam logic [6:0] F7_RESET   = 7'h07;  // block soft reset

  // Cycles between kernel_st and fmap_st for each kernel/layer mode
  localparam int DLY_K333    = 0;
  localparam int DLY_LAYER   = 2;
  localparam int DLY_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_DELAY = 2'd2,
    ST_RUN   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/hwpe_start_seq.sv
// Start sequencer: after an accepted MatrixMac it waits one ARM cycle for the
// config writes to settle, pulses kernel_st, then pulses fmap_st after a
// mode-dependent delay and stays in RUN until matrix_done.
module hwpe_start_seq
  import hwpe_dec_pkg::*;
#(
  parameter int DLY_W = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       kernel_333,
  input  logic       layer_type,
  input  logic       matrix_done,
  output seq_state_e state,
  output logic       busy,
  output logic       kernel_st,
  output logic       fmap_st,
  output logic       run_done
);

  seq_state_e       state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly;
  logic             kernel_st_q, kernel_st_d;
  logic             fmap_st_q, fmap_st_d;

  // Delay chosen from the mode bits as they stand during the ARM cycle
  always_comb begin
    if (kernel_333)      dly = DLY_W'(DLY_K333);
    else if (layer_type) dly = DLY_W'(DLY_LAYER);
    else                 dly = DLY_W'(DLY_DEFAULT);
  end

  // Next state, delay counter and registered start pulses; clr overrides all
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kernel_st_d = 1'b0;
    fmap_st_d   = 1'b0;
    run_done    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_ARM;
      ST_ARM: begin
        kernel_st_d = 1'b1;
        if (dly == '0) begin
          fmap_st_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          cnt_d   = dly - DLY_W'(1);
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) begin
          fmap_st_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      ST_RUN: begin
        if (matrix_done) begin
          state_d  = ST_IDLE;
          run_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      kernel_st_d = 1'b0;
      fmap_st_d   = 1'b0;
      run_done    = 1'b0;
    end
  end

  // State, counter and pulse registers
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    kernel_st_q <= kernel_st_d;
    fmap_st_q   <= fmap_st_d;
  end

  assign state     = state_q;
  assign busy      = (state_q != ST_IDLE);
  assign kernel_st = kernel_st_q;
  assign fmap_st   = fmap_st_q;

endmodule

// File: rtl/hwpe_instr_dec.sv
// HWPE custom-instruction decoder. Register-write/read decodes are plain
// funct7 compares; MatrixMac drives the start sequencer; chained accumulator
// / ReLU reads raise conv_st. Optional sticky error flag under the macro
// HWPE_DEC_ERR_EN (undefined: err is tied low).
// Handshake: a request is accepted on a rising edge where eai_req_valid and
// eai_req_ready are both high; every side effect keys off that accept only.
module hwpe_instr_dec
  import hwpe_dec_pkg::*;
#(
  parameter  int NUM_PE  = 16,
  parameter  int NUM_ACC = 8,
  parameter  int DLY_W   = 3,
  localparam int PE_W    = $clog2(NUM_PE),
  localparam int ACC_W   = $clog2(NUM_ACC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1_data,
  input  logic             eai_req_valid,
  input  logic             eai_req_ready,
  input  logic             kernel_333,
  input  logic             layer_type,
  input  logic             matrix_done,
  output logic             wr_fmap_addr,
  output logic             wr_cfg,
  output logic             acc_wen,
  output logic [PE_W-1:0]  acc_w_pe_id,
  output logic [ACC_W-1:0] acc_w_acc_id,
  output logic [31:0]      acc_w_wd,
  output logic             acc_ren,
  output logic [PE_W-1:0]  acc_r_pe_id,
  output logic [ACC_W-1:0] acc_r_acc_id,
  output logic             relu_ren,
  output logic [ACC_W-1:0] relu_acc_id,
  output logic             soft_rst,
  output logic             kernel_st,
  output logic             fmap_st,
  output logic             conv_st,
  output logic             busy,
  output logic             done_imm,
  output logic             err
);

  logic [6:0] funct7;
  logic       unused_instr;
  logic       accept, mac_acc, rst_acc, chain_req, clr, start;
  logic       in_run, in_idle, run_done;
  seq_state_e seq_state;
  logic       soft_rst_q, soft_rst_d;
  logic       done_q, done_d;
  logic       conv_st_q, conv_st_d;

  assign funct7       = instr[31:25];
  assign unused_instr = ^instr;

  assign wr_fmap_addr = (funct7 == F7_WR_FMAP);
  assign wr_cfg       = (funct7 == F7_WR_CFG);
  assign acc_wen      = (funct7 == F7_ACC_WR);
  assign acc_ren      = (funct7 == F7_ACC_RD);
  assign relu_ren     = (funct7 == F7_RELU);
  assign done_imm     = !((funct7 == F7_MAC) || (funct7 == F7_RELU));

  assign acc_w_pe_id  = instr[20 +: PE_W];
  assign acc_w_acc_id = instr[7 +: ACC_W];
  assign acc_w_wd     = rs1_data;
  assign acc_r_acc_id = instr[15 +: ACC_W];
  assign acc_r_pe_id  = instr[20 +: PE_W];
  assign relu_acc_id  = instr[20 +: ACC_W];

  assign accept    = eai_req_valid & eai_req_ready;
  assign mac_acc   = accept & (funct7 == F7_MAC);
  assign rst_acc   = accept & (funct7 == F7_RESET);
  // rs1[4] / rs2[4] request chaining the read into a convolution start
  assign chain_req = accept & ((acc_ren & instr[19]) | (relu_ren & instr[24]));
  // An accepted Reset clears the block on the same edge that raises soft_rst
  assign clr       = rst | soft_rst_q | rst_acc;
  assign start     = mac_acc & ~busy;
  assign in_run    = (seq_state == ST_RUN);
  assign in_idle   = (seq_state == ST_IDLE);

  hwpe_start_seq #(
    .DLY_W(DLY_W)
  ) u_start_seq (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .kernel_333  (kernel_333),
    .layer_type  (layer_type),
    .matrix_done (matrix_done),
    .state       (seq_state),
    .busy        (busy),
    .kernel_st   (kernel_st),
    .fmap_st     (fmap_st),
    .run_done    (run_done)
  );

  // Soft-reset request, done flag (a RUN has completed) and conv_st pulse
  always_comb begin
    soft_rst_d = rst ? 1'b0 : rst_acc;
    done_d     = done_q;
    conv_st_d  = 1'b0;
    if (clr) begin
      done_d = 1'b0;
    end else begin
      if (run_done) done_d = 1'b1;
      conv_st_d = chain_req & (in_run | (in_idle & done_q));
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    soft_rst_q <= soft_rst_d;
    done_q     <= done_d;
    conv_st_q  <= conv_st_d;
  end

  assign soft_rst = soft_rst_q;
  assign conv_st  = conv_st_q;

`ifdef HWPE_DEC_ERR_EN
  logic err_q, err_d;

  // Sticky error: MatrixMac while busy, or a chain with nothing to chain onto
  always_comb begin
    err_d = err_q;
    if (clr) err_d = 1'b0;
    else if ((mac_acc & busy) | (chain_req & ~done_q & ~in_run)) err_d = 1'b1;
  end

  // Error register
  always_ff @(posedge clk) begin
    err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hwpe_instr_dec.sv
// Testbench for hwpe_instr_dec (NUM_PE=32). A timestamp-based model predicts
// every output each cycle; directed steps cover start timing, chaining,
// soft/hard reset and field mapping, then a randomized phase follows.
module tb_hwpe_instr_dec;
  import hwpe_dec_pkg::*;

`ifdef HWPE_DEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] rs1_data = '0;
  logic        eai_req_valid = 1'b0, eai_req_ready = 1'b0;
  logic        kernel_333 = 1'b0, layer_type = 1'b0, matrix_done = 1'b0;
  logic        wr_fmap_addr, wr_cfg, acc_wen, acc_ren, relu_ren;
  logic [4:0]  acc_w_pe_id, acc_r_pe_id;
  logic [2:0]  acc_w_acc_id, acc_r_acc_id, relu_acc_id;
  logic [31:0] acc_w_wd;
  logic        soft_rst, kernel_st, fmap_st, conv_st, busy, done_imm, err;

  always #5 clk = ~clk;

  hwpe_instr_dec #(.NUM_PE(32), .NUM_ACC(8), .DLY_W(3)) dut (
    .clk(clk), .rst(rst), .instr(instr), .rs1_data(rs1_data),
    .eai_req_valid(eai_req_valid), .eai_req_ready(eai_req_ready),
    .kernel_333(kernel_333), .layer_type(layer_type), .matrix_done(matrix_done),
    .wr_fmap_addr(wr_fmap_addr), .wr_cfg(wr_cfg), .acc_wen(acc_wen),
    .acc_w_pe_id(acc_w_pe_id), .acc_w_acc_id(acc_w_acc_id), .acc_w_wd(acc_w_wd),
    .acc_ren(acc_ren), .acc_r_pe_id(acc_r_pe_id), .acc_r_acc_id(acc_r_acc_id),
    .relu_ren(relu_ren), .relu_acc_id(relu_acc_id), .soft_rst(soft_rst),
    .kernel_st(kernel_st), .fmap_st(fmap_st), .conv_st(conv_st),
    .busy(busy), .done_imm(done_imm), .err(err)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A MatrixMac accepted on edge m_e produces kernel_st after edge m_e+1 and
  // fmap_st after edge m_e+1+D; RUN holds from then on, so matrix_done counts
  // from edge m_e+2+D. D is taken from the mode bits at edge m_e+1.
  int ed    = 0;
  bit m_act = 1'b0;
  int m_e   = 0;
  int m_d   = 99;
  bit m_done = 1'b0, m_err = 1'b0, m_soft = 1'b0;
  bit e_kst = 1'b0, e_fst = 1'b0, e_conv = 1'b0;

  task automatic model_edge();
    logic [6:0] f;
    bit acc, mac, rreq, chain, busy_now, in_run;
    f     = instr[31:25];
    acc   = eai_req_valid && eai_req_ready;
    mac   = acc && (f == F7_MAC);
    rreq  = acc && (f == F7_RESET);
    chain = acc && (((f == F7_ACC_RD) && instr[19]) || ((f == F7_RELU) && instr[24]));
    e_conv = 1'b0;
    if (rst || rreq || m_soft) begin
      m_act  = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
      m_soft = !rst && rreq;
    end else begin
      m_soft   = 1'b0;
      busy_now = m_act;
      if (m_act && ed == m_e + 1) m_d = kernel_333 ? 0 : (layer_type ? 2 : 3);
      in_run = m_act && (ed >= m_e + 2 + m_d);
      if (chain && (in_run || (!busy_now && m_done))) e_conv = 1'b1;
      if (ERR_EN && ((mac && busy_now) || (chain && !m_done && !in_run))) m_err = 1'b1;
      if (in_run && matrix_done) begin
        m_act  = 1'b0;
        m_done = 1'b1;
      end
      if (mac && !busy_now) begin
        m_act = 1'b1;
        m_e   = ed;
        m_d   = 99;
      end
    end
    e_kst = m_act && (ed == m_e + 1);
    e_fst = m_act && (ed == m_e + 1 + m_d);
  endtask

  task automatic check_all();
    logic [6:0] f;
    f = instr[31:25];
    chk("busy", busy, m_act);
    chk("kernel_st", kernel_st, e_kst);
    chk("fmap_st", fmap_st, e_fst);
    chk("conv_st", conv_st, e_conv);
    chk("soft_rst", soft_rst, m_soft);
    chk("err", err, m_err);
    chk("wr_fmap_addr", wr_fmap_addr, f == F7_WR_FMAP);
    chk("wr_cfg", wr_cfg, f == F7_WR_CFG);
    chk("acc_wen", acc_wen, f == F7_ACC_WR);
    chk("acc_ren", acc_ren, f == F7_ACC_RD);
    chk("relu_ren", relu_ren, f == F7_RELU);
    chk("done_imm", done_imm, !(f == F7_MAC || f == F7_RELU));
    chk("acc_w_pe_id", acc_w_pe_id, instr[24:20]);
    chk("acc_w_acc_id", acc_w_acc_id, instr[9:7]);
    chk("acc_w_wd", acc_w_wd, rs1_data);
    chk("acc_r_pe_id", acc_r_pe_id, instr[24:20]);
    chk("acc_r_acc_id", acc_r_acc_id, instr[17:15]);
    chk("relu_acc_id", relu_acc_id, instr[22:20]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    ed++;
    model_edge();
    #1;
    check_all();
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'h0B};
  endfunction

  // One accepted request; returns just after its accept edge
  task automatic send(input logic [6:0] f7, input logic [4:0] rs2,
                      input logic [4:0] rs1, input logic [4:0] rd);
    instr = mk(f7, rs2, rs1, rd);
    eai_req_valid = 1'b1;
    eai_req_ready = 1'b1;
    tick();
    eai_req_valid = 1'b0;
    eai_req_ready = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_done();
    matrix_done = 1'b1;
    tick();
    matrix_done = 1'b0;
  endtask

  // Start a MAC; report the cycle numbers (accept cycle = 0) of the pulses
  task automatic run_mac(input bit k, input bit lt, output int kc, output int fc);
    kernel_333 = k;
    layer_type = lt;
    kc = 0;
    fc = 0;
    send(F7_MAC, 5'd0, 5'd0, 5'd0);
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (kc == 0 && kernel_st === 1'b1) kc = c;
      if (fc == 0 && fmap_st === 1'b1) fc = c;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kc, fc, seen;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_soft", soft_rst, 1'b0);
    chk("rst_err", err, 1'b0);

    // chain request before any MAC: no conv_st, error flagged
    send(F7_RELU, 5'h13, 5'd0, 5'd0);
    chk("pre_chain_conv", conv_st, 1'b0);
    chk("pre_chain_err", err, ERR_EN);
    chk("pre_chain_relu_id", relu_acc_id, 3'd3);
    do_rst();

    // valid held without ready: nothing starts
    instr = mk(F7_MAC, 5'd0, 5'd0, 5'd0);
    eai_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    eai_req_valid = 1'b0;
    chk("noready_busy", busy, 1'b0);

    // kernel_333: kernel_st and fmap_st together at cycle 2
    run_mac(1'b1, 1'b0, kc, fc);
    chk("k333_kernel_cyc", kc, 2);
    chk("k333_fmap_cyc", fc, 2);
    chk("k333_busy", busy, 1'b1);
    pulse_done();
    chk("k333_idle", busy, 1'b0);

    // chain after completed MAC: one conv_st pulse
    send(F7_RELU, 5'h13, 5'd0, 5'd0);
    chk("chain_conv", conv_st, 1'b1);
    chk("chain_relu_id", relu_acc_id, 3'd3);
    tick();
    chk("chain_conv_width", conv_st, 1'b0);

    // layer_type: fmap_st at cycle 4
    run_mac(1'b0, 1'b1, kc, fc);
    chk("layer_kernel_cyc", kc, 2);
    chk("layer_fmap_cyc", fc, 4);
    pulse_done();

    // default mode: fmap_st at cycle 5; MAC during RUN is dropped
    run_mac(1'b0, 1'b0, kc, fc);
    chk("dflt_kernel_cyc", kc, 2);
    chk("dflt_fmap_cyc", fc, 5);
    send(F7_MAC, 5'd0, 5'd0, 5'd0);
    chk("mac_in_run_err", err, ERR_EN);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (kernel_st === 1'b1 || fmap_st === 1'b1) seen++;
    end
    chk("mac_in_run_pulses", seen, 0);
    pulse_done();
    do_rst();

    // Reset instruction during DELAY
    kernel_333 = 1'b0;
    layer_type = 1'b0;
    send(F7_MAC, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    send(F7_RESET, 5'd0, 5'd0, 5'd0);
    chk("softrst_pulse", soft_rst, 1'b1);
    chk("softrst_idle", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fmap_st === 1'b1 || soft_rst === 1'b1) seen++;
    end
    chk("softrst_no_fmap", seen, 0);

    // hard reset during DELAY suppresses fmap_st
    send(F7_MAC, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    do_rst();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fmap_st === 1'b1) seen++;
    end
    chk("rst_no_fmap", seen, 0);
    chk("rst_mid_busy", busy, 1'b0);

    // field mapping with NUM_PE=32
    instr = mk(F7_ACC_WR, 5'h1F, 5'd0, 5'd5);
    rs1_data = 32'hDEADBEEF;
    tick();
    chk("map_pe_id", acc_w_pe_id, 5'd31);
    chk("map_acc_id", acc_w_acc_id, 3'd5);
    chk("map_wd", acc_w_wd, 32'hDEADBEEF);
    chk("map_wen", acc_wen, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [6:0] f;
      r = $urandom_range(0, 19);
      if (r == 0)       f = F7_RESET;
      else if (r <= 5)  f = F7_MAC;
      else if (r <= 9)  f = F7_RELU;
      else if (r <= 13) f = F7_ACC_RD;
      else if (r == 14) f = F7_WR_FMAP;
      else if (r == 15) f = F7_WR_CFG;
      else if (r == 16) f = F7_ACC_WR;
      else              f = 7'($urandom_range(0, 127));
      instr         = mk(f, 5'($urandom), 5'($urandom), 5'($urandom));
      rs1_data      = $urandom;
      eai_req_valid = ($urandom_range(0, 9) < 6);
      eai_req_ready = ($urandom_range(0, 9) < 6);
      kernel_333    = ($urandom_range(0, 2) == 0);
      layer_type    = $urandom_range(0, 1);
      matrix_done   = ($urandom_range(0, 5) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    eai_req_valid = 1'b0;
    matrix_done = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
